i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
- REQ-001: Parameter TARGET_ADDR, default 7'h50; 7-bit bus address this block responds to.
- REQ-002: i_clk  input  1  system clock; SCL/SDA are sampled in this domain; rate at least 20x the SCL rate.
- REQ-003: i_rst  input  1  reset, asynchronous, active-high.
- REQ-004: i_scl  input  1  bus SCL level, asynchronous to i_clk.
- REQ-005: i_sda  input  1  bus SDA level, asynchronous to i_clk.
- REQ-006: o_scl_oe  output  1  when 1, the pad pulls SCL low; when 0, SCL is released (open-drain).
- REQ-007: o_sda_oe  output  1  when 1, the pad pulls SDA low; when 0, SDA is released.
- REQ-008: o_rx_data  output  8  last byte written by the controller.
- REQ-009: o_rx_valid  output  1  one-i_clk pulse; o_rx_data is valid in the same cycle.
- REQ-010: o_tx_req  output  1  one-i_clk pulse requesting the next read byte.
- REQ-011: i_tx_data  input  8  read byte.
- REQ-012: i_tx_valid  input  1  i_tx_data is valid; used only when stretch is compiled in.
- REQ-013: o_start  output  1  one-cycle pulse on START or repeated START.
- REQ-014: o_stop  output  1  one-cycle pulse on STOP.
- REQ-015: o_busy  output  1  high from the address match until the STOP or the next START.
- REQ-016: o_rw  output  1  R/W bit of the last matched address byte (1 = read).

Function
- REQ-017: i_scl and i_sda shall each pass through a 2-flop synchronizer; all edge detection shall use the synchronized values and their one-cycle-delayed copies.
- REQ-018: START is SDA falling while SCL is high; STOP is SDA rising while SCL is high; both shall be detected in every state, including mid-byte.
- REQ-019: States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- REQ-020: START (or repeated START) → ADDR, with the bit counter cleared. STOP → IDLE from any state.
- REQ-021: Bits shall be sampled on the SCL rising edge, MSB first. SDA output shall change only in the cycle after an SCL falling edge is detected.
- REQ-022: ADDR, 8th bit: if addr[7:1] equals TARGET_ADDR → ADDR_ACK and latch o_rw; otherwise → WAIT_STOP with o_sda_oe held at 0.
- REQ-023: In ADDR_ACK and RX_ACK, o_sda_oe shall be 1 from the falling edge after bit 8 until the falling edge after bit 9.
- REQ-024: ADDR_ACK, at the falling edge ending the 9th clock: o_rw=0 → RX; o_rw=1 → TX, with o_tx_req pulsed and i_tx_data loaded into the shift register in that same cycle.
- REQ-025: RX: on the 8th rising edge, update o_rx_data and pulse o_rx_valid (exactly once per byte); then → RX_ACK. The block always ACKs written bytes.
- REQ-026: TX: o_sda_oe shall equal the inverse of the current shift-register MSB. After 8 bits, release SDA → TX_ACK.
- REQ-027: TX_ACK: sample SDA on the 9th rising edge. ACK (0) → TX, with o_tx_req pulsed and a new byte loaded at the following falling edge. NACK (1) → WAIT_STOP with SDA released.
- REQ-028: WAIT_STOP drives neither line and exits only on STOP or START.
- REQ-029: A repeated START arriving while o_sda_oe=1 shall release SDA in the same cycle the START is detected.

Reset
- REQ-030: While i_rst is high: state=IDLE; o_scl_oe=0; o_sda_oe=0; o_rx_data=8'h00; o_rx_valid, o_tx_req, o_start, o_stop, o_busy, o_rw all 0; synchronizers preset to 1.
- REQ-031: Reset asserted mid-transfer shall release both lines within the same clock edge; after release, the block ignores the bus until the next START.

Configuration
- REQ-032: Macro I2C_TARGET_STRETCH_EN.
  - Defined: when o_tx_req is pulsed, hold o_scl_oe=1 until i_tx_valid=1. Load i_tx_data in the cycle i_tx_valid is high, drive the MSB on SDA, then release SCL one cycle later.
  - Undefined: o_scl_oe is tied to 0, i_tx_valid is ignored, and i_tx_data is sampled in the o_tx_req cycle.

Verification
- REQ-033: Write to address 0x50, data 0xA5, 0x3C, then STOP → ACK on all three bytes; o_rx_valid pulses twice with 0xA5 then 0x3C; o_stop pulses once.
- REQ-034: Address 0x51 with W → no ACK (SDA high at 9th clock); no o_rx_valid pulses; o_busy stays 0.
- REQ-035: Read from 0x50 with i_tx_data 0xC3 then 0x7E; controller ACKs byte 1 and NACKs byte 2 → bus carries 0xC3, 0x7E; o_tx_req pulses twice; SDA released after byte 2.
- REQ-036: Write 0x50, 0x11, then repeated START, then read 0x50 → o_start pulses twice; o_rw goes 0→1; the read returns i_tx_data.
- REQ-037: i_rst pulsed during the ACK of the address byte → o_sda_oe=0 immediately; the following bytes are ignored until a new START.
- REQ-038: STRETCH_EN defined, i_tx_valid delayed 200 cycles → SCL held low for those 200 cycles; correct byte returned; no bit lost.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target at a fixed 7-bit address with byte-wide receive/transmit handshakes.
// Define I2C_TARGET_STRETCH_EN to hold SCL low on reads until i_tx_valid supplies the byte.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_busy,
  output logic       o_rw
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_t;

  state_t     state_reg, state_next;
  logic [1:0] scl_sync_reg, sda_sync_reg;
  logic       scl_dly_reg, sda_dly_reg;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       start_reg, start_next;
  logic       stop_reg, stop_next;
  logic       busy_reg, busy_next;
  logic       rw_reg, rw_next;
  logic       tx_req, load_tx;
`ifdef I2C_TARGET_STRETCH_EN
  logic       scl_oe_reg, scl_oe_next;
  logic       hold_reg, hold_next;
`endif

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_reg[1];
  assign sda_s     = sda_sync_reg[1];
  assign scl_rise  = scl_s & ~scl_dly_reg;
  assign scl_fall  = ~scl_s & scl_dly_reg;
  assign start_det = scl_s & scl_dly_reg & sda_dly_reg & ~sda_s;
  assign stop_det  = scl_s & scl_dly_reg & ~sda_dly_reg & sda_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_dly_reg  <= 1'b1;
      sda_dly_reg  <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], i_scl};
      sda_sync_reg <= {sda_sync_reg[0], i_sda};
      scl_dly_reg  <= scl_sync_reg[1];
      sda_dly_reg  <= sda_sync_reg[1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      sda_oe_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      rw_reg       <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_reg   <= 1'b0;
      hold_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      sda_oe_reg   <= sda_oe_next;
      rx_valid_reg <= rx_valid_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
      busy_reg     <= busy_next;
      rw_reg       <= rw_next;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_reg   <= scl_oe_next;
      hold_reg     <= hold_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    sda_oe_next   = sda_oe_reg;
    rx_valid_next = 1'b0;
    start_next    = 1'b0;
    stop_next     = 1'b0;
    busy_next     = busy_reg;
    rw_next       = rw_reg;
    tx_req        = 1'b0;
    load_tx       = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    scl_oe_next   = scl_oe_reg;
    hold_next     = hold_reg;
`endif
    case (state_reg)
      ADDR: if (scl_rise) begin
        shift_next   = {shift_reg[6:0], sda_s};
        bit_cnt_next = bit_cnt_reg + 4'd1;
        if (bit_cnt_reg == 4'd7) begin
          bit_cnt_next = 4'd0;
          // Seven address bits are already shifted in; the bit on this edge is R/W.
          if (shift_reg[6:0] == TARGET_ADDR) begin
            state_next = ADDR_ACK;
            rw_next    = sda_s;
            busy_next  = 1'b1;
          end else begin
            state_next = WAIT_STOP;
          end
        end
      end
      ADDR_ACK, RX_ACK: if (scl_fall) begin
        // sda_oe_reg doubles as the phase flag: first fall starts the ACK, second ends it.
        if (!sda_oe_reg) begin
          sda_oe_next = 1'b1;
        end else begin
          sda_oe_next = 1'b0;
          if (state_reg == ADDR_ACK && rw_reg) load_tx = 1'b1;
          else state_next = RX;
        end
      end
      RX: if (scl_rise) begin
        shift_next   = {shift_reg[6:0], sda_s};
        bit_cnt_next = bit_cnt_reg + 4'd1;
        if (bit_cnt_reg == 4'd7) begin
          rx_data_next  = {shift_reg[6:0], sda_s};
          rx_valid_next = 1'b1;
          bit_cnt_next  = 4'd0;
          state_next    = RX_ACK;
        end
      end
      TX: begin
`ifdef I2C_TARGET_STRETCH_EN
        if (hold_reg) begin
          if (i_tx_valid) begin
            hold_next   = 1'b0;
            shift_next  = i_tx_data;
            sda_oe_next = ~i_tx_data[7];
          end
        end else if (scl_oe_reg) begin
          scl_oe_next = 1'b0;
        end else
`endif
        if (scl_rise) begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_reg == 4'd8) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 4'd0;
            state_next   = TX_ACK;
          end else begin
            shift_next  = {shift_reg[6:0], 1'b0};
            sda_oe_next = ~shift_reg[6];
          end
        end
      end
      TX_ACK: begin
        if (scl_rise) begin
          if (sda_s) state_next = WAIT_STOP;
          else bit_cnt_next = 4'd1;
        end else if (scl_fall && bit_cnt_reg == 4'd1) begin
          load_tx = 1'b1;
        end
      end
      default: ;
    endcase

    if (load_tx) begin
      tx_req       = 1'b1;
      state_next   = TX;
      bit_cnt_next = 4'd0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_next  = 1'b1;
      hold_next    = 1'b1;
`else
      shift_next   = i_tx_data;
      sda_oe_next  = ~i_tx_data[7];
`endif
    end

    if (start_det || stop_det) begin
      state_next   = start_det ? ADDR : IDLE;
      start_next   = start_det;
      stop_next    = stop_det;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      tx_req       = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_next  = 1'b0;
      hold_next    = 1'b0;
`endif
    end
  end

`ifdef I2C_TARGET_STRETCH_EN
  assign o_scl_oe = scl_oe_reg;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = i_tx_valid;
  assign o_scl_oe        = 1'b0;
`endif
  // A repeated START lets go of SDA in its detection cycle, ahead of the register update.
  assign o_sda_oe   = sda_oe_reg & ~start_det;
  assign o_rx_data  = rx_data_reg;
  assign o_rx_valid = rx_valid_reg;
  assign o_tx_req   = tx_req;
  assign o_start    = start_reg;
  assign o_stop     = stop_reg;
  assign o_busy     = busy_reg;
  assign o_rw       = rw_reg;

endmodule
